// File: rtl/weight_stream_feeder.sv
// Purpose : pops weight words from the 128-in/64-out weight FIFO and streams them to the PE-array
//           weight port, framed into kernels (o_weight_last) and layers (o_layer_last + o_done).
// Latency : first o_weight_valid 2 cycles after the first o_fifo_rden; 1 word/cycle sustained.
// Backpr. : valid/ready; a 2-entry skid buffer absorbs the FIFO read latency, head held while stalled.
//
// Ports:
//   system_clk, rst_n              clock, asynchronous active-low reset
//   i_start, i_words_per_kernel,   start pulse (ignored unless idle) and layer configuration;
//   i_kernel_num                   a zero in either field is treated as 1
//   o_fifo_rden, i_fifo_rddata,    FIFO read port; data arrives the cycle after an accepted read
//   i_fifo_empty
//   o_weight_valid/_data/_last,    output stream with kernel-last and layer-last flags
//   o_layer_last, i_weight_ready
//   o_busy, o_done                 layer in progress, one-cycle completion pulse
module weight_stream_feeder #(
    parameter int DATA_W  = 64,
    parameter int KWORD_W = 10,
    parameter int KNUM_W  = 12
) (
    input  logic               system_clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [KWORD_W-1:0] i_words_per_kernel,
    input  logic [KNUM_W-1:0]  i_kernel_num,
    output logic               o_fifo_rden,
    input  logic [DATA_W-1:0]  i_fifo_rddata,
    input  logic               i_fifo_empty,
    output logic               o_weight_valid,
    output logic [DATA_W-1:0]  o_weight_data,
    output logic               o_weight_last,
    output logic               o_layer_last,
    input  logic               i_weight_ready,
    output logic               o_busy,
    output logic               o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic              klast;
        logic              llast;
    } entry_t;

    state_t state, state_nxt;

    // Configuration is stored as "last index" so no adder sits on the compare path.
    logic [KWORD_W-1:0] wpk_m1;
    logic [KNUM_W-1:0]  knum_m1;
    logic [KWORD_W-1:0] word_cnt;
    logic [KNUM_W-1:0]  kern_cnt;

    logic   inflight;
    logic   inflight_klast;
    logic   inflight_llast;
    logic [1:0] occ;
    entry_t head;
    entry_t tail;
    entry_t cap_entry;

    logic start_acc;
    logic rd_acc;
    logic hs;
    logic issue_klast;
    logic issue_llast;
    logic [1:0] committed;

    assign start_acc   = (state == S_IDLE) && i_start;
    assign issue_klast = (word_cnt == wpk_m1);
    assign issue_llast = issue_klast && (kern_cnt == knum_m1);

    assign o_weight_valid = (occ != 2'd0);
    assign o_weight_data  = head.dat;
    assign o_weight_last  = o_weight_valid && head.klast;
    assign o_layer_last   = o_weight_valid && head.llast;
    assign hs             = o_weight_valid && i_weight_ready;

    // Entries the buffer will hold once this cycle's handshake retires the head; counting the
    // handshake as free space is what lets a read issue every cycle with ready held high.
    // hs implies occ >= 1, so the subtraction never wraps; occ + inflight never exceeds 2.
    assign committed = occ + {1'b0, inflight} - {1'b0, hs};

    // RUN is only ever occupied while words remain to be issued, so no separate issued<total term.
    assign o_fifo_rden = (state == S_RUN) && !i_fifo_empty && (committed < 2'd2);
    assign rd_acc      = o_fifo_rden;

    assign cap_entry = {i_fifo_rddata, inflight_klast, inflight_llast};

    // ---------------------------------------------------------------- configuration and issue counters
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            wpk_m1   <= '0;
            knum_m1  <= '0;
            word_cnt <= '0;
            kern_cnt <= '0;
        end else if (start_acc) begin
            wpk_m1   <= (i_words_per_kernel == '0) ? '0 : i_words_per_kernel - KWORD_W'(1);
            knum_m1  <= (i_kernel_num == '0) ? '0 : i_kernel_num - KNUM_W'(1);
            word_cnt <= '0;
            kern_cnt <= '0;
        end else if (rd_acc) begin
            if (issue_klast) begin
                word_cnt <= '0;
                kern_cnt <= kern_cnt + KNUM_W'(1);
            end else begin
                word_cnt <= word_cnt + KWORD_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------- read in flight (FIFO latency)
    // Flags are decided at issue time and travel with the read so they line up with its data.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight       <= 1'b0;
            inflight_klast <= 1'b0;
            inflight_llast <= 1'b0;
        end else begin
            inflight       <= rd_acc;
            inflight_klast <= issue_klast;
            inflight_llast <= issue_llast;
        end
    end

    // ---------------------------------------------------------------- 2-entry skid buffer
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            occ  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else if (inflight && hs) begin
            // Capture and retire together: occupancy holds, entries shift.
            if (occ == 2'd2) begin
                head <= tail;
                tail <= cap_entry;
            end else begin
                head <= cap_entry;
            end
        end else if (inflight) begin
            if (occ == 2'd0) begin
                head <= cap_entry;
            end else begin
                tail <= cap_entry;
            end
            occ <= occ + 2'd1;
        end else if (hs) begin
            head <= tail;
            occ  <= occ - 2'd1;
        end
    end

    // ---------------------------------------------------------------- layer FSM
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (rd_acc && issue_llast) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                o_busy = 1'b1;
                if (hs && head.llast) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_done    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
